axis_box_downscaler: RTL
========================

Name: axis_box_downscaler

Overview:
- 2x2 box-filter downscaler on the 8-bit AXI4-Stream video path; the decimating counterpart to the nearest-neighbour x2 upscaler.
- Takes IMG_RES_X x N frames (tuser = SOF, tlast = EOL) and emits (IMG_RES_X/2) x (N/2) frames.
- Each output pixel is the rounded mean of a 2x2 input block.
- Sits between the 4-to-1 and 1-to-4 AXIS width converters, in place of the upscaler core.

Parameters:
- IMG_RES_X, default 0: input line width in pixels. Must be even and >= 2. Any other value triggers $error at elaboration.

Ports:
- axis_aclk  in  1  clock
- axis_aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  8  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of input line
- s_axis_tuser  in  1  start of input frame
- m_axis_tdata  out  8  output pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  end of output line
- m_axis_tuser  out  1  start of output frame
- line_err  out  1  one-cycle pulse on input line-length violation

Behaviour:
- Reset: one clock; reset is asynchronous, active-low.
  - While reset is asserted: all outputs 0, including s_axis_tready.
  - Internal state cleared: x_cnt=0, row_odd=0, sof_pend=0, output register empty.
  - s_axis_tready rises on the first clock after release.
  - Reset mid-frame discards all partial data. Output resumes only after the next input tuser.
- State:
  - x_cnt: 0..IMG_RES_X-1.
  - row_odd: line parity.
  - h_reg: 8 bits, holds the even-x pixel.
  - Line buffer: IMG_RES_X/2 entries x 9 bits.
  - sof_pend: set when a frame start is accepted.
  - Single-stage output register.
- Accepted beat = s_axis_tvalid & s_axis_tready.
- Even row:
  - Even x: h_reg <= pixel.
  - Odd x: linebuf[x_cnt>>1] <= h_reg + pixel (9 bits).
  - No output is produced. s_axis_tready = 1.
- Odd row:
  - Even x: h_reg <= pixel. Issue a read of linebuf[x_cnt>>1]; the registered read data is valid on the next acceptance.
  - Odd x: sum = linebuf_q + h_reg + pixel (10 bits). Output = (sum + 2) >> 2; maximum is 255, so no saturation is needed.
  - That output is loaded into the output register. m_axis_tvalid rises on the next cycle (latency 1).
- Ready rule: s_axis_tready = ~row_odd | ~x_cnt[0] | ~m_axis_tvalid | m_axis_tready. This gives full throughput under no backpressure and no data loss under backpressure.
- The output register holds tdata, tlast and tuser stable while tvalid=1 and tready=0.
- m_axis_tlast = 1 on the output pixel produced at x_cnt == IMG_RES_X-1.
- m_axis_tuser = 1 on the first output pixel after sof_pend is set; sof_pend clears when that pixel loads.
- SOF handling (accepted beat with tuser=1, any position):
  - Forces x_cnt=0, row_odd=0, sof_pend=1; the beat is processed as pixel 0 of row 0.
  - A mid-line SOF aborts the current line. Already-loaded output is still delivered.
  - If the previous line was incomplete, line_err pulses.
- Line end:
  - At x_cnt == IMG_RES_X-1: x_cnt wraps to 0 and row_odd toggles, regardless of tlast.
  - If tlast=0 at that point, line_err pulses.
- Early tlast (tlast=1 at x_cnt < IMG_RES_X-1):
  - line_err pulses, x_cnt <= 0, row_odd toggles.
  - An unpaired even-x pixel is dropped. Output pixels already emitted for that line stand.
  - No m_axis_tlast is generated for the truncated output line.
- Odd input line count: the trailing even row is discarded at the next SOF.
- Simultaneous SOF with tlast: SOF takes priority for counters. tlast is checked only for line_err, against IMG_RES_X-1.

Test Plan:
- IMG_RES_X=4, frame [10,20,30,40]/[50,60,70,80], tuser on first beat, tlast on beats 4 and 8, m_axis_tready=1 -> outputs 35 then 55; 35 carries tuser, 55 carries tlast; line_err never pulses.
- Rounding, IMG_RES_X=2, three two-row frames -> blocks {0,0,0,1}->0, {0,0,1,1}->1, all 255 -> 255.
- Backpressure, IMG_RES_X=8, m_axis_tready toggling 1010... with tvalid held -> s_axis_tready drops only on odd-x beats of odd rows while output is stalled; all 4 output pixels per line emitted in order and correct; tdata is stable while stalled.
- Early tlast at x_cnt=2 on row 0 (IMG_RES_X=8) -> line_err pulse, next beat treated as row 1 x=0, no output tlast for that truncated line; a following SOF restores correct output.
- Mid-line SOF on row 1 x=3 -> line_err pulse, counters reset, next output pixel carries m_axis_tuser=1.
- Assert axis_aresetn low mid odd row -> all outputs 0 asynchronously; after release no output until SOF; then the next frame is correct.

Source files
------------

// File: rtl/axis_box_downscaler.sv
// 2x2 box-filter downscaler for an 8-bit AXI4-Stream video path.
// Each output pixel is the rounded mean of a 2x2 input block (tuser = SOF, tlast = EOL).
module axis_box_downscaler #(
    parameter int IMG_RES_X = 0
) (
    input  logic       axis_aclk,
    input  logic       axis_aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       line_err
);

    if ((IMG_RES_X < 2) || ((IMG_RES_X % 2) != 0)) begin : g_bad_res
        $error("axis_box_downscaler: IMG_RES_X must be even and >= 2");
    end

    localparam int XW    = (IMG_RES_X > 2) ? $clog2(IMG_RES_X) : 1;
    localparam int HALF  = (IMG_RES_X >= 2) ? IMG_RES_X / 2 : 1;
    localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1;
    // Depth rounded up to a power of two so every address value is in range.
    localparam int DEPTH = 1 << AW;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_RES_X - 1);

    logic          run;
    logic          synced;
    logic          row_odd;
    logic          sof_pend;
    logic [XW-1:0] x_cnt;
    logic [7:0]    h_reg;
    logic [8:0]    lb_mem [DEPTH];
    logic [8:0]    lb_q;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_user;
    logic          err_q;

    logic          beat;
    logic          sof;
    logic          take;
    logic [XW-1:0] eff_x;
    logic          eff_odd;
    logic          at_end;
    logic [AW-1:0] lb_addr;
    logic          load;
    logic [9:0]    sum;
    logic [7:0]    avg;
    logic          err_next;

    // Only the odd-x beat of an odd row can need the output register, so only it waits.
    assign s_axis_tready = run & (~row_odd | ~x_cnt[0] | ~out_valid | m_axis_tready);

    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    assign m_axis_tuser  = out_user;
    assign line_err      = err_q;

    always_comb begin
        beat     = s_axis_tvalid & s_axis_tready;
        sof      = beat & s_axis_tuser;
        take     = beat & (synced | s_axis_tuser);
        eff_x    = sof ? '0 : x_cnt;
        eff_odd  = sof ? 1'b0 : row_odd;
        at_end   = (eff_x == X_LAST);
        lb_addr  = AW'(eff_x >> 1);
        load     = take & eff_odd & eff_x[0];
        sum      = 10'(lb_q) + 10'(h_reg) + 10'(s_axis_tdata);
        avg      = 8'((sum + 10'd2) >> 2);
        err_next = take & ((sof & (x_cnt != '0))
                         | (at_end & ~s_axis_tlast)
                         | (~at_end & s_axis_tlast));
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            run       <= 1'b0;
            synced    <= 1'b0;
            row_odd   <= 1'b0;
            sof_pend  <= 1'b0;
            x_cnt     <= '0;
            h_reg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            run   <= 1'b1;
            err_q <= err_next;
            if (sof) begin
                synced <= 1'b1;
            end
            if (take) begin
                if (!eff_x[0]) begin
                    h_reg <= s_axis_tdata;
                end
                // A SOF beat never wraps on its own tlast: it is always pixel 0.
                if (at_end || (s_axis_tlast && !sof)) begin
                    x_cnt   <= '0;
                    row_odd <= ~eff_odd;
                end else begin
                    x_cnt   <= eff_x + 1'b1;
                    row_odd <= eff_odd;
                end
            end
            if (sof) begin
                sof_pend <= 1'b1;
            end else if (load) begin
                sof_pend <= 1'b0;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= avg;
                out_last  <= at_end;
                out_user  <= sof_pend;
            end else if (m_axis_tready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line buffer holds horizontal pair sums of the even row; read is registered.
    always_ff @(posedge axis_aclk) begin
        if (take && !eff_odd && eff_x[0]) begin
            lb_mem[lb_addr] <= 9'(h_reg) + 9'(s_axis_tdata);
        end
        if (take && eff_odd && !eff_x[0]) begin
            lb_q <= lb_mem[lb_addr];
        end
    end

endmodule
